// File: rtl/grf_write_arbiter.sv
// Write-port arbiter for the GeneralRegisterFile: the pipeline writeback always wins,
// buffered long-latency results drain into idle slots in order.
module grf_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [4:0]               pipeWriteAddress,
  input  logic [31:0]              pipeWriteData,
  input  logic                     lluValid,
  output logic                     lluReady,
  input  logic [4:0]               lluAddress,
  input  logic [31:0]              lluData,
  output logic [4:0]               grfWriteAddress,
  output logic [31:0]              grfWriteData,
  input  logic [4:0]               queryAddress1,
  input  logic [4:0]               queryAddress2,
  output logic                     queryPending1,
  output logic                     queryPending2,
  output logic                     stallRequest,
  output logic [$clog2(DEPTH):0]   pendingCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [4:0]       entryAddress [DEPTH];
  logic [31:0]      entryData    [DEPTH];
  logic [DEPTH-1:0] entryLive;
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic [AW:0]      count;
  logic [SW-1:0]    starve;

  logic pipeActive;
  logic fifoEmpty;
  logic push;
  logic pop;

  assign pipeActive   = (pipeWriteAddress != 5'd0);
  assign fifoEmpty    = (count == '0);
  assign lluReady     = (count < (AW+1)'(DEPTH));
  assign push         = lluValid && lluReady && (lluAddress != 5'd0);
  assign pop          = !pipeActive && !fifoEmpty;
  assign pendingCount = count;
  assign stallRequest = (starve == SW'(MAX_STARVE));

  always_comb begin
    grfWriteAddress = pipeWriteAddress;
    grfWriteData    = pipeWriteData;
    if (pop) begin
      grfWriteAddress = entryLive[rdPtr] ? entryAddress[rdPtr] : 5'd0;
      grfWriteData    = entryData[rdPtr];
    end
  end

  // Live bits are cleared on pop, so a set bit always marks a stored, unkilled entry.
  always_comb begin
    queryPending1 = 1'b0;
    queryPending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryLive[i] && (entryAddress[i] == queryAddress1))
        queryPending1 = 1'b1;
      if (entryLive[i] && (entryAddress[i] == queryAddress2))
        queryPending2 = 1'b1;
    end
    if (queryAddress1 == 5'd0)
      queryPending1 = 1'b0;
    if (queryAddress2 == 5'd0)
      queryPending2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entryAddress[wrPtr] <= lluAddress;
      entryData[wrPtr]    <= lluData;
    end
  end

  // The push assignment comes last so an entry enqueued on a killing edge stays live.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entryLive <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipeActive && (entryAddress[i] == pipeWriteAddress))
          entryLive[i] <= 1'b0;
      end
      if (pop)
        entryLive[rdPtr] <= 1'b0;
      if (push)
        entryLive[wrPtr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + AW'(1);
      if (pop)
        rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve <= '0;
    end else if (fifoEmpty || pop) begin
      starve <= '0;
    end else if (pipeActive && (starve != SW'(MAX_STARVE))) begin
      starve <= starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed vector table, hand sequences for starvation
// and asynchronous reset, then random traffic against a queue-based model.
module tb_grf_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int MAX_STARVE = 8;
  localparam logic [31:0] IDLE_DATA = 32'hA5A5_0000;

  logic        clk;
  logic        resetn;
  logic [4:0]  pipeWriteAddress;
  logic [31:0] pipeWriteData;
  logic        lluValid;
  logic        lluReady;
  logic [4:0]  lluAddress;
  logic [31:0] lluData;
  logic [4:0]  grfWriteAddress;
  logic [31:0] grfWriteData;
  logic [4:0]  queryAddress1;
  logic [4:0]  queryAddress2;
  logic        queryPending1;
  logic        queryPending2;
  logic        stallRequest;
  logic [2:0]  pendingCount;

  grf_write_arbiter #(.DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .resetn(resetn),
    .pipeWriteAddress(pipeWriteAddress), .pipeWriteData(pipeWriteData),
    .lluValid(lluValid), .lluReady(lluReady), .lluAddress(lluAddress), .lluData(lluData),
    .grfWriteAddress(grfWriteAddress), .grfWriteData(grfWriteData),
    .queryAddress1(queryAddress1), .queryAddress2(queryAddress2),
    .queryPending1(queryPending1), .queryPending2(queryPending2),
    .stallRequest(stallRequest), .pendingCount(pendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        v;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  q1;
    logic [4:0]  q2;
  } stim_t;

  typedef struct {
    logic        ready;
    logic [4:0]  ga;
    logic [31:0] gd;
    logic        p1;
    logic        p2;
    logic        stall;
    logic [2:0]  cnt;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  int   compared   = 0;
  int   mismatched = 0;
  ent_t fifo[$];
  int   starveModel = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit modelPending(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (fifo[i]) if (fifo[i].live && fifo[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs this cycle, from the list of buffered results and the input pattern.
  function automatic exp_t modelExpect(stim_t s);
    exp_t e;
    e.ready = (fifo.size() < DEPTH);
    e.ga    = s.pa;
    e.gd    = s.pd;
    if (s.pa == 5'd0 && fifo.size() > 0) begin
      e.ga = fifo[0].live ? fifo[0].a : 5'd0;
      e.gd = fifo[0].d;
    end
    e.p1    = modelPending(s.q1);
    e.p2    = modelPending(s.q2);
    e.stall = (starveModel == MAX_STARVE);
    e.cnt   = 3'(fifo.size());
    return e;
  endfunction

  function automatic void modelEdge(stim_t s);
    int   sz = fifo.size();
    bit   doPop = (s.pa == 5'd0) && (sz > 0);
    ent_t n;
    if (s.pa != 5'd0)
      foreach (fifo[i]) if (fifo[i].a == s.pa) fifo[i].live = 1'b0;
    if (sz == 0 || doPop) starveModel = 0;
    else if (s.pa != 5'd0 && starveModel < MAX_STARVE) starveModel++;
    if (doPop) fifo.delete(0);
    if (s.v && sz < DEPTH && s.la != 5'd0) begin
      n.a = s.la; n.d = s.ld; n.live = 1'b1;
      fifo.push_back(n);
    end
  endfunction

  function automatic void modelReset();
    fifo.delete();
    starveModel = 0;
  endfunction

  task automatic driveInputs(stim_t s);
    pipeWriteAddress = s.pa;
    pipeWriteData    = s.pd;
    lluValid         = s.v;
    lluAddress       = s.la;
    lluData          = s.ld;
    queryAddress1    = s.q1;
    queryAddress2    = s.q2;
  endtask

  task automatic checkOutput(exp_t e, string tag);
    chk({tag, ".lluReady"},        32'(lluReady),        32'(e.ready));
    chk({tag, ".grfWriteAddress"}, 32'(grfWriteAddress), 32'(e.ga));
    chk({tag, ".grfWriteData"},    grfWriteData,         e.gd);
    chk({tag, ".queryPending1"},   32'(queryPending1),   32'(e.p1));
    chk({tag, ".queryPending2"},   32'(queryPending2),   32'(e.p2));
    chk({tag, ".stallRequest"},    32'(stallRequest),    32'(e.stall));
    chk({tag, ".pendingCount"},    32'(pendingCount),    32'(e.cnt));
  endtask

  // One cycle: drive after the edge, check mid-cycle, advance the model at the edge.
  task automatic applyStimulus(stim_t s, bit useTable, exp_t te, string tag);
    driveInputs(s);
    @(negedge clk);
    checkOutput(useTable ? te : modelExpect(s), tag);
    @(posedge clk);
    modelEdge(s);
    #1;
  endtask

  function automatic stim_t mkStim(logic [4:0] pa, logic [31:0] pd, logic v, logic [4:0] la,
                                   logic [31:0] ld, logic [4:0] q1, logic [4:0] q2);
    stim_t s;
    s.pa = pa; s.pd = pd; s.v = v; s.la = la; s.ld = ld; s.q1 = q1; s.q2 = q2;
    return s;
  endfunction

  function automatic vec_t mk(stim_t s, logic ready, logic [4:0] ga, logic [31:0] gd,
                              logic p1, logic p2, logic stall, logic [2:0] cnt);
    vec_t r;
    r.s = s;
    r.e.ready = ready; r.e.ga = ga; r.e.gd = gd; r.e.p1 = p1; r.e.p2 = p2;
    r.e.stall = stall; r.e.cnt = cnt;
    return r;
  endfunction

  vec_t  tbl[11];
  exp_t  dummy;
  stim_t s;
  stim_t busy;
  stim_t idle;

  initial begin
    dummy = '{default: '0};
    idle  = mkStim(5'd0, IDLE_DATA, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    resetn = 1'b0;
    driveInputs(idle);

    // Basic drain, kill, same-edge enqueue and address-0 handshake, in sequence from reset.
    tbl[0]  = mk(mkStim(5'd0, IDLE_DATA, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0), 1, 5'd0, IDLE_DATA,    0, 0, 0, 3'd0);
    tbl[1]  = mk(mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0,        5'd5, 5'd5), 1, 5'd5, 32'hDEADBEEF, 1, 1, 0, 3'd1);
    tbl[2]  = mk(mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0,        5'd5, 5'd0), 1, 5'd0, IDLE_DATA,    0, 0, 0, 3'd0);
    tbl[3]  = mk(mkStim(5'd3, 32'h100,   1, 5'd7, 32'h11,       5'd7, 5'd0), 1, 5'd3, 32'h100,      0, 0, 0, 3'd0);
    tbl[4]  = mk(mkStim(5'd7, 32'h22,    0, 5'd0, 32'd0,        5'd7, 5'd3), 1, 5'd7, 32'h22,       1, 0, 0, 3'd1);
    tbl[5]  = mk(mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0,        5'd7, 5'd0), 1, 5'd0, 32'h11,       0, 0, 0, 3'd1);
    tbl[6]  = mk(mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0,        5'd0, 5'd0), 1, 5'd0, IDLE_DATA,    0, 0, 0, 3'd0);
    tbl[7]  = mk(mkStim(5'd9, 32'h200,   1, 5'd9, 32'h33,       5'd9, 5'd0), 1, 5'd9, 32'h200,      0, 0, 0, 3'd0);
    tbl[8]  = mk(mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0,        5'd9, 5'd0), 1, 5'd9, 32'h33,       1, 0, 0, 3'd1);
    tbl[9]  = mk(mkStim(5'd0, IDLE_DATA, 1, 5'd0, 32'h44,       5'd0, 5'd0), 1, 5'd0, IDLE_DATA,    0, 0, 0, 3'd0);
    tbl[10] = mk(mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0,        5'd0, 5'd0), 1, 5'd0, IDLE_DATA,    0, 0, 0, 3'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset.lluReady", 32'(lluReady), 32'd1);
    chk("reset.stallRequest", 32'(stallRequest), 32'd0);
    chk("reset.pendingCount", 32'(pendingCount), 32'd0);
    chk("reset.grfWriteData", grfWriteData, IDLE_DATA);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++)
      applyStimulus(tbl[i].s, 1'b1, tbl[i].e, $sformatf("vec%0d", i));

    // Starvation: pipe writes $3 every cycle while four results fill the buffer.
    modelReset();
    for (int c = 0; c < 4; c++)
      applyStimulus(mkStim(5'd3, 32'h300 + 32'(c), 1, 5'(8 + c), 32'h1000 + 32'(c), 5'(8 + c), 5'd11),
                    1'b0, dummy, $sformatf("fill%0d", c));
    chk("full.lluReady", 32'(lluReady), 32'd0);
    chk("full.pendingCount", 32'(pendingCount), 32'd4);
    chk("full.stallRequest", 32'(stallRequest), 32'd0);
    busy = mkStim(5'd3, 32'h333, 1, 5'd12, 32'hBAD, 5'd8, 5'd12);
    for (int c = 4; c <= 9; c++) begin
      applyStimulus(busy, 1'b0, dummy, $sformatf("starve%0d", c));
      chk($sformatf("starve%0d.stallRequest", c), 32'(stallRequest), (c >= 8) ? 32'd1 : 32'd0);
    end
    s = mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0, 5'd8, 5'd9);
    driveInputs(s);
    #1;
    chk("bubble.grfWriteAddress", 32'(grfWriteAddress), 32'd8);
    chk("bubble.grfWriteData", grfWriteData, 32'h1000);
    applyStimulus(s, 1'b0, dummy, "bubble");
    chk("afterBubble.stallRequest", 32'(stallRequest), 32'd0);
    chk("afterBubble.lluReady", 32'(lluReady), 32'd1);
    chk("afterBubble.pendingCount", 32'(pendingCount), 32'd3);

    // Build up a stall again with three entries, then reset asynchronously mid-cycle.
    busy = mkStim(5'd3, 32'h444, 0, 5'd0, 32'd0, 5'd9, 5'd10);
    for (int c = 0; c < MAX_STARVE; c++)
      applyStimulus(busy, 1'b0, dummy, $sformatf("restarve%0d", c));
    chk("preReset.stallRequest", 32'(stallRequest), 32'd1);
    chk("preReset.pendingCount", 32'(pendingCount), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk("asyncReset.pendingCount", 32'(pendingCount), 32'd0);
    chk("asyncReset.lluReady", 32'(lluReady), 32'd1);
    chk("asyncReset.stallRequest", 32'(stallRequest), 32'd0);
    chk("asyncReset.queryPending1", 32'(queryPending1), 32'd0);
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      s = mkStim(5'd0, IDLE_DATA, 0, 5'd0, 32'd0, 5'd9, 5'd10);
      driveInputs(s);
      #1;
      chk($sformatf("postReset%0d.grfWriteAddress", c), 32'(grfWriteAddress), 32'd0);
      applyStimulus(s, 1'b0, dummy, $sformatf("postReset%0d", c));
    end

    // Random traffic over a small register range so kills and pending hits are frequent.
    for (int c = 0; c < 400; c++) begin
      s.pa = ($urandom_range(0, 9) < 5) ? 5'd0 : 5'($urandom_range(1, 7));
      s.pd = $urandom;
      s.v  = 1'($urandom_range(0, 1));
      s.la = 5'($urandom_range(0, 7));
      s.ld = $urandom;
      s.q1 = 5'($urandom_range(0, 7));
      s.q2 = 5'($urandom_range(0, 7));
      applyStimulus(s, 1'b0, dummy, $sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/grf_write_arbiter.md
Name: grf_write_arbiter

Overview:
- Single initiator for the GeneralRegisterFile write port.
- Merges the in-order pipeline writeback stream with results from long-latency units (mult/div, uncached loads).
- Long-latency results are buffered in a small FIFO and drained into idle writeback slots.
- Exports per-register pending status so decode can stall on RAW/WAW hazards against buffered results.

Parameters:
- DEPTH, 4, FIFO entries for long-latency results; power of 2, ≥2.
- MAX_STARVE, 8, consecutive blocked-drain cycles before a pipeline bubble is requested.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- pipeWriteAddress  input  5  pipeline writeback destination; 0 = no write this cycle.
- pipeWriteData  input  32  pipeline writeback data.
- lluValid  input  1  long-latency result valid.
- lluReady  output  1  FIFO can accept a result.
- lluAddress  input  5  long-latency destination register.
- lluData  input  32  long-latency result data.
- grfWriteAddress  output  5  to register file writeAddress; 0 = no write.
- grfWriteData  output  32  to register file writeData.
- queryAddress1  input  5  decode source register 1.
- queryAddress2  input  5  decode source register 2.
- queryPending1  output  1  queryAddress1 has a live buffered write.
- queryPending2  output  1  queryAddress2 has a live buffered write.
- stallRequest  output  1  request a writeback bubble next cycle.
- pendingCount  output  $clog2(DEPTH)+1  occupied FIFO entries, live or dead.

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO empty; all live bits 0; rd/wr pointers 0; starve counter 0.
  - Outputs during and after reset: lluReady=1, stallRequest=0, queryPending*=0, pendingCount=0.
  - grfWriteAddress/Data pass through the pipe inputs (FIFO empty).
  - Reset mid-operation discards all buffered results without writing them.
- Accept:
  - lluReady = (count < DEPTH), computed from registered count only. No same-cycle pop-then-push when full.
  - Handshake lluValid && lluReady enqueues {address, data, live=1} at the edge.
  - lluAddress==0 is handshaken but not enqueued.
- Write selection (combinational):
  - If pipeWriteAddress != 0: grf outputs = pipe inputs. Pipeline always wins.
  - Else if FIFO non-empty: grf outputs = head; grfWriteAddress = head address if head live, else 0. Head pops at the edge.
  - Else: outputs = pipe inputs (address 0).
- Latency: an accepted LLU result reaches the grf port no earlier than the cycle after acceptance. No same-cycle bypass.
- Kill (WAW ordering):
  - At each edge with pipeWriteAddress != 0, every stored live entry whose address matches is cleared to dead.
  - An entry enqueued on that same edge is younger and is not killed.
  - Dead entries still occupy a slot and consume one drain slot with no write.
- Pending query:
  - queryPendingN = OR over stored live entries of (address == queryAddressN).
  - queryAddressN == 0 always returns 0.
  - An entry being enqueued this cycle is not yet visible.
- Starvation:
  - Counter increments each edge where the FIFO is non-empty and pipeWriteAddress != 0.
  - Counter clears on any pop or when the FIFO is empty; it saturates at MAX_STARVE.
  - stallRequest = (counter == MAX_STARVE), registered; it holds until the first pop.
- Pointers wrap modulo DEPTH. count = 0..DEPTH. Simultaneous push and pop (when not full) leaves count unchanged.

Test Plan:
- Reset, then lluValid=1, lluAddress=5, lluData=0xDEADBEEF, pipe idle:
  - lluReady=1.
  - Next cycle: grfWriteAddress=5, grfWriteData=0xDEADBEEF, queryPending(5)=1 during that cycle.
  - Following cycle: pending=0, count=0.
- Pipe writes $3 every cycle; push DEPTH results to $8..$11:
  - lluReady=0 once count=4.
  - stallRequest rises MAX_STARVE=8 cycles after the first blocked drain.
  - After a one-cycle pipe bubble: $8 written, stallRequest=0, lluReady=1.
- Enqueue $7=0x11 while pipe busy; next cycle pipe writes $7=0x22:
  - Entry goes dead; queryPending(7)=0.
  - Drain slot emits grfWriteAddress=0; the register file keeps 0x22.
- Same edge: pipe writes $9 and LLU enqueues $9=0x33:
  - The new entry stays live and later writes 0x33.
- lluAddress=0 handshake:
  - Accepted, count unchanged, no write produced.
- Assert resetn low asynchronously with 3 entries buffered and stallRequest=1:
  - Immediately count=0, lluReady=1, stallRequest=0, no buffered write ever appears.
